// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction prefetch unit.
// Queue entries carry the package widths; instantiate fetch_prefetch with
// AWIDTH/DWIDTH equal to FETCH_AWIDTH/FETCH_DWIDTH.
package fetch_pkg;

    localparam int          FETCH_AWIDTH   = 32;
    localparam int          FETCH_DWIDTH   = 32;
    localparam logic [31:0] FETCH_BASEADDR = 32'h0100_0000;

    // One prefetched instruction together with the PC it was fetched from
    typedef struct packed {
        logic [FETCH_AWIDTH-1:0] pc;
        logic [FETCH_DWIDTH-1:0] insn;
    } fetch_entry_t;

    // RUN fetches normally; HALT is only reachable with FETCH_MISALIGN_TRAP_EN
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO of fetch_entry_t with synchronous flush.
// head is the registered storage slot, so a pushed entry becomes visible on
// the cycle after the push (no write-through bypass). A push into a full
// queue succeeds when a pop happens in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = DEPTH[PW:0];

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     cnt_q;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt_q;

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    // Entry storage, no reset needed since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: sequential PC fetch into a small queue feeding
// decode, with redirect flush and drop accounting for in-flight responses.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect halts
// fetch and raises fetch_misalign; otherwise the target is word aligned).
//
// Handshakes: a transfer happens on a rising edge where valid && ready; valid
// never depends combinationally on the matching ready. Memory responses
// return in request order, one per accepted request, at least one cycle later.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int                AWIDTH   = FETCH_AWIDTH,
    parameter int                DWIDTH   = FETCH_DWIDTH,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(FETCH_BASEADDR),
    parameter int                DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    output logic [AWIDTH-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DWIDTH-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic              dec_valid,
    output logic [AWIDTH-1:0] dec_pc,
    output logic [DWIDTH-1:0] dec_insn,
    input  logic              dec_ready,
    output logic              fetch_misalign
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    // Drop count is wider than the queue: back-to-back redirects can stack
    // several generations of abandoned requests in the memory pipeline.
    localparam int          DROP_W  = CW + 4;
    localparam logic [CW:0] DEPTH_L = DEPTH[CW:0];

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [AWIDTH-1:0] pc_q;
    logic [AWIDTH-1:0] rsp_pc_q;      // PC of the next response that will be kept
    logic [CW-1:0]     out_q;         // accepted requests whose response is wanted
    logic [DROP_W-1:0] drop_q;        // responses still to be discarded
    logic [AWIDTH-1:0] redir_pc;
    logic [CW:0]       inflight_sum;
    logic              accept;
    logic              rsp_drop;
    logic              rsp_keep;
    logic              dec_pop;

    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // Low two bits are cleared; with the trap enabled a nonzero pair halts instead
    assign redir_pc     = redirect_pc & ~AWIDTH'(3);
    assign inflight_sum = {1'b0, fifo_count} + {1'b0, out_q};

    assign imem_req_valid = !reset && (state_q == ST_RUN) && !fifo_full &&
                            (inflight_sum < DEPTH_L);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response is discarded while drops are pending, on a redirect, or in HALT
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid &&
                      (state_q == ST_RUN);
    // Redirect beats the decode handshake: the head is flushed, not consumed
    assign dec_pop  = !fifo_empty && dec_ready && !redirect_valid;

    assign push_entry.pc   = FETCH_AWIDTH'(rsp_pc_q);
    assign push_entry.insn = FETCH_DWIDTH'(imem_rsp_data);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (dec_pop),
        .flush     (redirect_valid),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign dec_valid = !fifo_empty;
    assign dec_pc    = AWIDTH'(head_entry.pc);
    assign dec_insn  = DWIDTH'(head_entry.insn);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Next state: only a misaligned redirect (trap build) leaves RUN
    always_comb begin
        state_d = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (state_q == ST_RUN && redirect_valid && redirect_pc[1:0] != 2'b00)
            state_d = ST_HALT;
`endif
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misalign = (state_q == ST_HALT);
`else
    assign fetch_misalign = 1'b0;
`endif

    // PC, response PC, outstanding and drop counters
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= BASEADDR;
            rsp_pc_q <= BASEADDR;
            out_q    <= '0;
            drop_q   <= '0;
        end else if (redirect_valid) begin
            // Everything in flight, including a request accepted right now,
            // becomes a drop; a response arriving now consumes one of them.
            pc_q     <= redir_pc;
            rsp_pc_q <= redir_pc;
            out_q    <= '0;
            drop_q   <= drop_q + DROP_W'(out_q) + DROP_W'(accept)
                        - DROP_W'(imem_rsp_valid);
        end else begin
            if (accept)   pc_q     <= pc_q + AWIDTH'(4);
            if (rsp_keep) rsp_pc_q <= rsp_pc_q + AWIDTH'(4);
            if (rsp_drop) drop_q   <= drop_q - DROP_W'(1);
            out_q <= out_q + CW'(accept) - CW'(rsp_keep);
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: in-order memory model with random latency, a
// queue-based reference of what decode must see, directed scenarios and a
// randomized run with redirects and mid-operation resets.
module tb_fetch_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0100_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_insn;
    logic        dec_ready;
    logic        fetch_misalign;

    fetch_prefetch #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_pc         (dec_pc),
        .dec_insn       (dec_insn),
        .dec_ready      (dec_ready),
        .fetch_misalign (fetch_misalign)
    );

    // ---------------- clock / reset defaults ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } flight_t;

    flight_t     inflight[$];     // requests accepted by memory, oldest first
    logic [63:0] exp_q[$];        // {pc, insn} decode must see, oldest first
    logic [31:0] dec_log[$];      // PCs consumed by decode
    logic [31:0] exp_pc;
    bit          halted;
    bit          m_mis;
    int          cyc;
    int          last_due;
    int          drop_seen;
    int          rdy_pct, drdy_pct, lat_min, lat_max;
    int          n_checks, n_err;

    logic        last_req_valid, last_dec_valid, last_mis;
    logic [31:0] last_req_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (inflight[i]) if (inflight[i].live) n++;
        return n;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        return (i < dec_log.size()) ? dec_log[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- driver + per-cycle compare ----------------
    task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc);
        bit          m_req, m_dec, acc, hs, rsp;
        logic [31:0] rdata;
        flight_t     f;
        int          lat;
        @(negedge clk);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        dec_ready      = ($urandom_range(99) < drdy_pct);
        rsp            = !rst && inflight.size() > 0 && inflight[0].due <= cyc;
        rdata          = rsp ? mem_data(inflight[0].addr) : $urandom();
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdata;
        #1;
        m_req = !rst && !halted && (exp_q.size() + live_cnt() < DEPTH);
        m_dec = exp_q.size() > 0;
        last_req_valid = imem_req_valid;
        last_req_addr  = imem_req_addr;
        last_dec_valid = dec_valid;
        last_mis       = fetch_misalign;
        check("req_valid", imem_req_valid, m_req);
        if (!rst) begin
            if (m_req) check("req_addr", imem_req_addr, exp_pc);
            check("dec_valid", dec_valid, m_dec);
            if (m_dec) begin
                check("dec_pc", dec_pc, exp_q[0][63:32]);
                check("dec_insn", dec_insn, exp_q[0][31:0]);
            end
            check("fetch_misalign", fetch_misalign, m_mis);
        end
        acc = m_req && imem_req_ready;
        hs  = m_dec && dec_ready;
        @(posedge clk);
        cyc++;
        if (rst) begin
            inflight.delete();
            exp_q.delete();
            exp_pc   = BASE;
            halted   = 0;
            m_mis    = 0;
            last_due = 0;
        end else begin
            if (rsp) begin
                f = inflight.pop_front();
                if (f.live && !redir) exp_q.push_back({f.addr, rdata});
                else                  drop_seen++;
            end
            if (acc) begin
                lat = cyc + $urandom_range(lat_max, lat_min);
                if (lat < last_due) lat = last_due;
                last_due = lat;
                inflight.push_back('{exp_pc, lat, 1'b1});
                exp_pc = exp_pc + 32'd4;
            end
            if (redir) begin
                foreach (inflight[i]) inflight[i].live = 1'b0;
                exp_q.delete();
                exp_pc = rpc & ~32'h3;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (rpc[1:0] != 2'b00) begin
                    halted = 1;
                    m_mis  = 1;
                end
`endif
            end else if (hs) begin
                dec_log.push_back(exp_q[0][63:32]);
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) cycle(1'b1, 1'b0, $urandom());
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0, 1'b0, $urandom());
    endtask

    logic [31:0] tgt, acc_addr, head_pc;
    int          hits, r;
    bit          found;

    initial begin
        n_checks = 0; n_err = 0; cyc = 0; drop_seen = 0; last_due = 0;
        halted = 0; m_mis = 0; exp_pc = BASE;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b0;
        rdy_pct = 100; drdy_pct = 100; lat_min = 0; lat_max = 0;

        // Sequential fetch from reset with a one-cycle memory
        do_reset(2);
        dec_log.delete();
        cycle(1'b0, 1'b0, 32'h0);
        check("first_req_valid", last_req_valid, 1'b1);
        check("first_req_addr", last_req_addr, 32'h0100_0000);
        run(12);
        check("seq_pc0", log_at(0), 32'h0100_0000);
        check("seq_pc1", log_at(1), 32'h0100_0004);
        check("seq_pc2", log_at(2), 32'h0100_0008);

        // Decode stalls: queue fills to DEPTH and requests stop
        drdy_pct = 0;
        run(10);
        check("stall_model_occ", exp_q.size(), DEPTH);
        check("stall_req_valid", last_req_valid, 1'b0);
        check("stall_dec_valid", last_dec_valid, 1'b1);
        drdy_pct = 100;
        run(10);

        // Redirect with two requests outstanding
        do_reset(1);
        lat_min = 2; lat_max = 2;
        run(2);
        check("two_outstanding", live_cnt(), 2);
        rdy_pct = 0; drop_seen = 0; dec_log.delete();
        cycle(1'b0, 1'b1, 32'h0100_0100);
        rdy_pct = 100;
        run(15);
        check("drop_count", drop_seen, 2);
        check("redir_pc0", log_at(0), 32'h0100_0100);
        check("redir_pc1", log_at(1), 32'h0100_0104);

        // Address wrap at the top of the address space
        lat_min = 0; lat_max = 2;
        dec_log.delete();
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
        run(20);
        check("wrap_pc0", log_at(0), 32'hFFFF_FFF8);
        check("wrap_pc1", log_at(1), 32'hFFFF_FFFC);
        check("wrap_pc2", log_at(2), 32'h0000_0000);
        check("wrap_pc3", log_at(3), 32'h0000_0004);

        // Misaligned redirect
        dec_log.delete();
        cycle(1'b0, 1'b1, 32'h0100_0102);
        run(12);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_flag", last_mis, 1'b1);
        check("mis_req_stopped", last_req_valid, 1'b0);
        do_reset(1);
`else
        check("mis_flag", last_mis, 1'b0);
        check("mis_aligned_pc", log_at(0), 32'h0100_0100);
`endif

        // Redirect coinciding with a decode handshake and a request accept
        lat_min = 0; lat_max = 0;
        run(4);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (!halted && exp_q.size() > 0 && exp_q.size() + live_cnt() < DEPTH) found = 1;
            else run(1);
        end
        check("collision_setup", found, 1'b1);
        acc_addr = exp_pc;
        head_pc  = (exp_q.size() > 0) ? exp_q[0][63:32] : 32'h0;
        dec_log.delete();
        cycle(1'b0, 1'b1, 32'h0100_0200);
        run(12);
        check("collision_pc0", log_at(0), 32'h0100_0200);
        hits = 0;
        foreach (dec_log[i]) if (dec_log[i] == acc_addr || dec_log[i] == head_pc) hits++;
        check("collision_no_stale", hits, 0);

        // Randomized traffic with redirects and resets
        rdy_pct = 75; drdy_pct = 70; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(99);
            if (halted && r < 20) do_reset($urandom_range(2, 1));
            else if (r == 0) do_reset($urandom_range(2, 1));
            else if (r < 4) begin
                case ($urandom_range(3))
                    0: tgt = 32'h0100_0000 | ($urandom() & 32'h0000_FFFC);
                    1: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(3) * 4);
                    2: tgt = 32'h0200_0000 | ($urandom() & 32'h0000_FFFF);
                    default: tgt = $urandom() & ~32'h3;
                endcase
                cycle(1'b0, 1'b1, tgt);
            end else run(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 Parameter AWIDTH, default 32, PC/address width.
REQ-002 Parameter DWIDTH, default 32, instruction width.
REQ-003 Parameter BASEADDR, default 32'h0100_0000, PC reset value.
REQ-004 Parameter DEPTH, default 4, prefetch queue entries; power of two, >=2.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_addr  output  AWIDTH  fetch address, word aligned.
REQ-009 imem_req_ready  input  1  memory accepts request when valid&ready.
REQ-010 imem_rsp_valid  input  1  in-order response, one per accepted request, latency >=1 cycle.
REQ-011 imem_rsp_data  input  DWIDTH  instruction word.
REQ-012 redirect_valid  input  1  branch/jump redirect, single-cycle pulse.
REQ-013 redirect_pc  input  AWIDTH  redirect target.
REQ-014 dec_valid  output  1  queue head valid to decode.
REQ-015 dec_pc  output  AWIDTH  PC of head entry.
REQ-016 dec_insn  output  DWIDTH  instruction of head entry.
REQ-017 dec_ready  input  1  decode consumes head when dec_valid&dec_ready.
REQ-018 fetch_misalign  output  1  sticky misaligned-redirect flag.

Function
REQ-019 PC register SHALL advance by 4 on each accepted request, modulo 2^AWIDTH (FFFF_FFFC -> 0000_0000, no saturation, no return to BASEADDR).
REQ-020 imem_req_valid SHALL assert iff state RUN and (queue occupancy + outstanding) < DEPTH; imem_req_addr = PC register.
REQ-021 Responses SHALL be written to the queue with their request PC; dec_valid asserts the cycle after the response (no bypass), queue order preserved.
REQ-022 Full queue: no request issued; empty queue: dec_valid=0; simultaneous push and pop at full/empty SHALL both succeed without loss.
REQ-023 Redirect SHALL: flush queue, load PC with redirect_pc, convert all outstanding requests (including one accepted that same cycle) into a drop count; dropped responses never enter the queue.
REQ-024 Redirect SHALL win over a same-cycle dec handshake and request acceptance; the redirected request issues no earlier than the next cycle.
REQ-025 States: RUN (normal), HALT (macro only); RUN->HALT on misaligned redirect; HALT exits only on reset.
REQ-026 All dec_pc and imem_req_addr values SHALL have bits [1:0]=00.

Reset
REQ-027 On reset: PC=BASEADDR, queue empty, outstanding=0, drop count=0, state RUN, fetch_misalign=0, dec_valid=0.
REQ-028 imem_req_valid SHALL be 0 while reset high and 1 with addr BASEADDR in the first cycle after reset deasserts.
REQ-029 Reset mid-operation SHALL discard queue and outstanding counts; responses to pre-reset requests are not tracked (memory reset jointly).

Configuration
REQ-030 Macro FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=00 enters HALT, sets fetch_misalign, flushes, stops requests.
REQ-031 Macro undefined: redirect_pc[1:0] forced to 00, state always RUN, fetch_misalign tied 0.

Structure
REQ-032 Package fetch_pkg SHALL hold AWIDTH/DWIDTH defaults, BASEADDR, fetch_entry_t {pc, insn}, fetch_state_t enum.
REQ-033 Queue SHALL be sub-module fetch_fifo (DEPTH, fetch_entry_t, push/pop/flush, full/empty/count).
REQ-034 RTL SHALL be 120-400 lines total.

Verification
REQ-035 Reset release, ready=1, 1-cycle memory -> addrs 0100_0000, 0100_0004, 0100_0008...; dec_pc matches, step +4.
REQ-036 dec_ready=0 for 10 cycles -> exactly DEPTH entries queued, requests stop, no loss; resume -> in-order delivery.
REQ-037 Redirect to 0100_0100 with 2 outstanding -> 2 responses dropped, next dec_pc = 0100_0100.
REQ-038 Redirect to FFFF_FFF8 -> dec_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-039 Macro on, redirect to 0100_0102 -> fetch_misalign=1, imem_req_valid=0 until reset; macro off -> fetch from 0100_0100.
REQ-040 Redirect same cycle as dec handshake and req accept -> that accepted request's response dropped, head not re-presented.
